// File: rtl/ps2_pkg.sv
// Shared types, frame constants and parity helper for the PS/2 receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int   PS2_DATA_BITS = 8;
  localparam logic PS2_START     = 1'b0;
  localparam logic PS2_STOP      = 1'b1;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous FIFO with first-word-fall-through output and an overflow pulse.
module ps2_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push while full is still taken.
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign o_data     = r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow = r_overflow;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_push && !w_do_push;
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin sync, clock de-glitch, frame check, byte FIFO.
// state  | meaning
// IDLE   | waiting for a start bit
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking the stop bit, pushing a good byte
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILTER_LEN = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CK,
  input  logic       RSTN,
  input  logic       Ps2Ck,
  input  logic       Ps2Dat,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic       RxReady,
  output logic       ParityErr,
  output logic       FrameErr,
  output logic       Overflow,
  output logic       Busy
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam int FW          = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic                     r_ck_s1, r_ck_s2, r_dat_s1, r_dat_s2;
  logic                     r_fck, r_fck_d;
  logic [FW-1:0]            r_flt_cnt;
  ps2_state_t               r_state;
  logic [2:0]               r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic                     r_par;
  logic [TW-1:0]            r_tmo;
  logic                     r_parity_err, r_frame_err;
  logic                     w_fall, w_timeout, w_push, w_empty, w_full;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_ck_s1   <= 1'b1;
      r_ck_s2   <= 1'b1;
      r_dat_s1  <= 1'b1;
      r_dat_s2  <= 1'b1;
      r_fck     <= 1'b1;
      r_fck_d   <= 1'b1;
      r_flt_cnt <= FW'(FILTER_LEN - 1);
    end else begin
      r_ck_s1  <= Ps2Ck;
      r_ck_s2  <= r_ck_s1;
      r_dat_s1 <= Ps2Dat;
      r_dat_s2 <= r_dat_s1;
      r_fck_d  <= r_fck;
      // Any return to the accepted level restarts the stability window.
      if (r_ck_s2 == r_fck) begin
        r_flt_cnt <= FW'(FILTER_LEN - 1);
      end else if (r_flt_cnt == '0) begin
        r_fck     <= r_ck_s2;
        r_flt_cnt <= FW'(FILTER_LEN - 1);
      end else begin
        r_flt_cnt <= r_flt_cnt - 1'b1;
      end
    end
  end

  assign w_fall    = r_fck_d && !r_fck;
  assign w_timeout = (r_state != IDLE) && (r_tmo == TW'(TIMEOUT_CYC));
  assign w_push    = (r_state == STOP) && w_fall && !w_timeout &&
                     (r_dat_s2 == PS2_STOP) && odd_parity_ok(r_shift, r_par);

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)                          r_tmo <= '0;
    else if (r_state == IDLE || w_fall) r_tmo <= '0;
    else if (!w_timeout)                r_tmo <= r_tmo + 1'b1;
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_timeout) begin
        r_state     <= IDLE;
        r_frame_err <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          IDLE: begin
            if (r_dat_s2 == PS2_START) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          DATA: begin
            r_shift <= {r_dat_s2, r_shift[PS2_DATA_BITS-1:1]};
            if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) r_state <= PARITY;
            else                                    r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= STOP;
          end
          STOP: begin
            // A bad stop bit masks a parity error on the same frame.
            if (r_dat_s2 != PS2_STOP)                r_frame_err  <= 1'b1;
            else if (!odd_parity_ok(r_shift, r_par)) r_parity_err <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  ps2_rx_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CK         (CK),
    .RSTN       (RSTN),
    .i_push     (w_push),
    .i_data     (r_shift),
    .i_pop      (RxReady),
    .o_data     (RxData),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_overflow (Overflow)
  );

  assign RxValid   = !w_empty;
  assign ParityErr = r_parity_err;
  assign FrameErr  = r_frame_err;
  assign Busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: random and directed PS/2 frames against a frame-level model.
module tb_ps2_rx;

  localparam int CLK_HZ      = 1000000;
  localparam int TIMEOUT_US  = 400;
  localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int FILTER_LEN  = 8;
  localparam int DEPTH       = 4;
  localparam int HP          = 25;

  logic       CK = 1'b0;
  logic       RSTN = 1'b0;
  logic       Ps2Ck = 1'b1;
  logic       Ps2Dat = 1'b1;
  logic       RxReady;
  logic [7:0] RxData;
  logic       RxValid, ParityErr, FrameErr, Overflow, Busy;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         perr_exp = 0, fe_exp = 0, ovf_exp = 0;
  int         perr_cnt = 0, fe_cnt = 0, ovf_cnt = 0;
  bit         rand_mode = 0;
  logic       ready_fixed = 1'b1;

  ps2_rx #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FILTER_LEN (FILTER_LEN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CK        (CK),
    .RSTN      (RSTN),
    .Ps2Ck     (Ps2Ck),
    .Ps2Dat    (Ps2Dat),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .RxReady   (RxReady),
    .ParityErr (ParityErr),
    .FrameErr  (FrameErr),
    .Overflow  (Overflow),
    .Busy      (Busy)
  );

  initial forever #5 CK = ~CK;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  initial begin
    RxReady = 1'b1;
    forever begin
      @(posedge CK);
      #1;
      RxReady = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Monitor: pops the scoreboard on every handshake, counts pulses, checks hold stability.
  initial begin
    logic [7:0] prev_data;
    bit         prev_hold;
    prev_hold = 0;
    prev_data = '0;
    forever begin
      @(negedge CK);
      if (!RSTN) begin
        prev_hold = 0;
      end else begin
        if (ParityErr) perr_cnt++;
        if (FrameErr)  fe_cnt++;
        if (Overflow)  ovf_cnt++;
        if (prev_hold) begin
          check("hold_valid", int'(RxValid), 1);
          check("hold_data", int'(RxData), int'(prev_data));
        end
        if (RxValid && RxReady) begin
          if (exp_q.size() == 0) check("unexpected_byte", int'(RxData), -1);
          else check("rx_data", int'(RxData), int'(exp_q.pop_front()));
        end
        prev_hold = RxValid && !RxReady;
        prev_data = RxData;
      end
    end
  end

  task automatic ck_pulse(input logic d, input bit glitch);
    Ps2Dat = d;
    if (glitch) begin
      wait_clk(12);
      Ps2Ck = 1'b0;
      wait_clk(4);
      Ps2Ck = 1'b1;
      wait_clk(HP - 16);
    end else begin
      wait_clk(HP);
    end
    Ps2Ck = 1'b0;
    wait_clk(HP);
    Ps2Ck = 1'b1;
  endtask

  // Reference model: outcome of a whole frame from its bits, decided before sending.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input bit glitch);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    if (!stp) fe_exp++;
    else if ((($countones(d) + int'(par)) % 2) == 0) perr_exp++;
    else if (!rand_mode && !ready_fixed && exp_q.size() >= DEPTH) ovf_exp++;
    else exp_q.push_back(d);
    for (int i = 0; i < 11; i++) ck_pulse(bits[i], glitch && (i == 3));
    Ps2Dat = 1'b1;
    wait_clk(HP);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, 1'b0, d, 1'b0};
    for (int i = 0; i < nbits; i++) ck_pulse(bits[i], 0);
    Ps2Dat = 1'b1;
  endtask

  task automatic check_counts(input string tag);
    wait_clk(40);
    check({tag, "_perr"}, perr_cnt, perr_exp);
    check({tag, "_ferr"}, fe_cnt, fe_exp);
    check({tag, "_ovf"}, ovf_cnt, ovf_exp);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  initial begin
    wait_clk(5);
    check("rst_valid", int'(RxValid), 0);
    check("rst_data", int'(RxData), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_errs", int'({ParityErr, FrameErr, Overflow}), 0);
    RSTN = 1'b1;
    wait_clk(20);

    send_frame(8'h1C, 1'b0, 1'b1, 0);
    check_counts("good_1c");

    send_frame(8'h1C, 1'b1, 1'b1, 0);
    check_counts("parity_bad");
    send_frame(8'hF0, 1'b1, 1'b1, 0);
    check_counts("after_perr");

    send_partial(8'h1C, 5);
    wait_clk(5);
    check("busy_mid_frame", int'(Busy), 1);
    fe_exp++;
    wait_clk(TIMEOUT_CYC + 40);
    check("busy_after_tmo", int'(Busy), 0);
    check_counts("timeout");
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    check_counts("after_tmo");

    ck_pulse(1'b1, 0);
    fe_exp++;
    wait_clk(HP);
    check_counts("stray_edge");

    ready_fixed = 1'b0;
    wait_clk(2);
    for (int i = 1; i <= 5; i++) send_frame(8'(i), odd_par(8'(i)), 1'b1, 0);
    wait_clk(40);
    check("ovf_count", ovf_cnt, ovf_exp);
    check("ovf_expected_one", ovf_exp, 1);
    check("full_valid", int'(RxValid), 1);
    check("full_head", int'(RxData), 1);
    ready_fixed = 1'b1;
    wait_clk(20);
    check("drained_valid", int'(RxValid), 0);
    check_counts("overflow");

    Ps2Dat = 1'b1;
    Ps2Ck = 1'b0;
    wait_clk(4);
    Ps2Ck = 1'b1;
    wait_clk(30);
    check("idle_glitch_busy", int'(Busy), 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1);
    check_counts("glitch");

    send_partial(8'h29, 5);
    wait_clk(5);
    RSTN = 1'b0;
    wait_clk(3);
    check("rst_mid_valid", int'(RxValid), 0);
    check("rst_mid_busy", int'(Busy), 0);
    check("rst_mid_data", int'(RxData), 0);
    RSTN = 1'b1;
    wait_clk(20);
    check("post_rst_busy", int'(Busy), 0);
    send_frame(8'h29, 1'b0, 1'b1, 0);
    check_counts("after_rst");

    rand_mode = 1;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       p, s;
      d = 8'($urandom);
      p = odd_par(d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, p, s, bit'($urandom_range(0, 1)));
    end
    rand_mode = 0;
    ready_fixed = 1'b1;
    begin
      int budget;
      budget = 200;
      while (exp_q.size() != 0 && budget > 0) begin
        wait_clk(1);
        budget--;
      end
    end
    check_counts("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
